// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the score path of the game: binary score width,
// BCD digit count, the score tracker state encoding and the per-nibble
// BCD correction used during binary-to-BCD conversion.
// No ports (package).
// -----------------------------------------------------------------------------
package dino_pkg;

   // Binary score width shared by the game logic and the score renderer.
   localparam int SCORE_W = 11;
   // BCD digits shown; 10^DIGITS must exceed 2^SCORE_W.
   localparam int DIGITS  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Double-dabble nibble correction: a digit of 5..9 would become >= 10
   // after the next doubling, so pre-add 3 to carry into the next digit.
   function automatic logic [3:0] add3_fix(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational BCD nibble correction for shift-and-add-3 conversion.
// Ports:
//   in_nib   in  4  BCD digit before correction
//   out_nib  out 4  in_nib + 3 when in_nib >= 5, otherwise in_nib
// -----------------------------------------------------------------------------
module bcd_add3
   import dino_pkg::*;
(
   input  logic [3:0] in_nib,
   output logic [3:0] out_nib
);

   assign out_nib = add3_fix(in_nib);

endmodule

// File: rtl/score_bcd_tracker.sv
// -----------------------------------------------------------------------------
// score_bcd_tracker
// Converts the binary game score to packed BCD with a sequential double-dabble
// (one shift per game tick), and tracks the high score plus a new-record flag.
// A score of 0 marks a game restart and clears the new-record flag; rst clears
// the high score as well.
// Ports:
//   clk_20Hz    in   1          game tick clock, rising edge
//   rst         in   1          asynchronous active-high reset
//   score       in   SCORE_W    binary score, sampled only while idle
//   cur_bcd     out  4*DIGITS   last converted score, digit 0 in [3:0]
//   hi_bcd      out  4*DIGITS   high score in packed BCD
//   upd         out  1          one-tick pulse: cur_bcd/hi_bcd just written
//   new_record  out  1          current game has beaten the previous high
//   busy        out  1          conversion in progress
// -----------------------------------------------------------------------------
module score_bcd_tracker #(
   parameter int SCORE_W = dino_pkg::SCORE_W,
   parameter int DIGITS  = dino_pkg::DIGITS
) (
   input  logic                  clk_20Hz,
   input  logic                  rst,
   input  logic [SCORE_W-1:0]    score,
   output logic [4*DIGITS-1:0]   cur_bcd,
   output logic [4*DIGITS-1:0]   hi_bcd,
   output logic                  upd,
   output logic                  new_record,
   output logic                  busy
);

   import dino_pkg::*;

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = 4;
   // Shift index of the final shift; SCORE_W shifts in total.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_W - 1);

   state_t               state_q, state_d;
   logic [SCORE_W-1:0]   last_bin_q, last_bin_d;
   logic [SCORE_W-1:0]   hi_bin_q, hi_bin_d;
   logic [SCORE_W-1:0]   sh_bin_q, sh_bin_d;
   // Copy of the value being converted: sh_bin is consumed by the shifts.
   logic [SCORE_W-1:0]   conv_bin_q, conv_bin_d;
   logic [BCD_W-1:0]     sh_bcd_q, sh_bcd_d;
   logic [BCD_W-1:0]     cur_bcd_q, cur_bcd_d;
   logic [BCD_W-1:0]     hi_bcd_q, hi_bcd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 upd_q, upd_d;
   logic                 new_record_q, new_record_d;
   logic                 busy_q, busy_d;
   logic [BCD_W-1:0]     adj_s;

   // One correction cell per BCD digit of the shift register.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .in_nib  (sh_bcd_q[4*g +: 4]),
         .out_nib (adj_s[4*g +: 4])
      );
   end

   // Next-state and datapath logic for the conversion/high-score FSM.
   always_comb begin
      state_d      = state_q;
      last_bin_d   = last_bin_q;
      hi_bin_d     = hi_bin_q;
      sh_bin_d     = sh_bin_q;
      conv_bin_d   = conv_bin_q;
      sh_bcd_d     = sh_bcd_q;
      cur_bcd_d    = cur_bcd_q;
      hi_bcd_d     = hi_bcd_q;
      cnt_d        = cnt_q;
      upd_d        = 1'b0;
      new_record_d = new_record_q;

      case (state_q)
         IDLE: begin
            if (score != last_bin_q) begin
               sh_bin_d   = score;
               conv_bin_d = score;
               sh_bcd_d   = {BCD_W{1'b0}};
               cnt_d      = {CNT_W{1'b0}};
               state_d    = SHIFT;
            end else begin
               state_d    = IDLE;
            end
         end

         SHIFT: begin
            // Shift the corrected digits and the binary left by one; the
            // binary MSB enters BCD digit 0.
            {sh_bcd_d, sh_bin_d} = {adj_s[BCD_W-2:0], sh_bin_q, 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end

         DONE: begin
            cur_bcd_d  = sh_bcd_q;
            last_bin_d = conv_bin_q;
            upd_d      = 1'b1;
            // Strictly greater only: tying the high score is not a record.
            if (conv_bin_q > hi_bin_q) begin
               hi_bin_d     = conv_bin_q;
               hi_bcd_d     = sh_bcd_q;
               new_record_d = 1'b1;
            end else if (conv_bin_q == {SCORE_W{1'b0}}) begin
               new_record_d = 1'b0;
            end else begin
               new_record_d = new_record_q;
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered busy tracks the state being entered.
      busy_d = (state_d != IDLE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_20Hz or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_bin_q   <= {SCORE_W{1'b0}};
         hi_bin_q     <= {SCORE_W{1'b0}};
         sh_bin_q     <= {SCORE_W{1'b0}};
         conv_bin_q   <= {SCORE_W{1'b0}};
         sh_bcd_q     <= {BCD_W{1'b0}};
         cur_bcd_q    <= {BCD_W{1'b0}};
         hi_bcd_q     <= {BCD_W{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         upd_q        <= 1'b0;
         new_record_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_bin_q   <= last_bin_d;
         hi_bin_q     <= hi_bin_d;
         sh_bin_q     <= sh_bin_d;
         conv_bin_q   <= conv_bin_d;
         sh_bcd_q     <= sh_bcd_d;
         cur_bcd_q    <= cur_bcd_d;
         hi_bcd_q     <= hi_bcd_d;
         cnt_q        <= cnt_d;
         upd_q        <= upd_d;
         new_record_q <= new_record_d;
         busy_q       <= busy_d;
      end
   end

   assign cur_bcd    = cur_bcd_q;
   assign hi_bcd     = hi_bcd_q;
   assign upd        = upd_q;
   assign new_record = new_record_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_score_bcd_tracker.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_tracker
// Self-checking bench for score_bcd_tracker. Expected values come from a
// decimal-arithmetic model of the score/high-score rules.
// -----------------------------------------------------------------------------
module tb_score_bcd_tracker;

   logic        clk_20Hz;
   logic        rst;
   logic [10:0] score;
   logic [15:0] cur_bcd;
   logic [15:0] hi_bcd;
   logic        upd;
   logic        new_record;
   logic        busy;

   int errors;
   int checks;

   // Reference model state
   int m_last;
   int m_hi;
   int m_cur;
   bit m_nr;

   score_bcd_tracker #(.SCORE_W(11), .DIGITS(4)) dut (
      .clk_20Hz   (clk_20Hz),
      .rst        (rst),
      .score      (score),
      .cur_bcd    (cur_bcd),
      .hi_bcd     (hi_bcd),
      .upd        (upd),
      .new_record (new_record),
      .busy       (busy)
   );

   initial clk_20Hz = 1'b0;
   always #5 clk_20Hz = ~clk_20Hz;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[3:0]   = 4'(v % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[15:12] = 4'((v / 1000) % 10);
      return r;
   endfunction

   task automatic model_reset();
      m_last = 0;
      m_hi   = 0;
      m_cur  = 0;
      m_nr   = 1'b0;
   endtask

   task automatic model_convert(input int v);
      m_cur  = v;
      m_last = v;
      if (v > m_hi) begin
         m_hi = v;
         m_nr = 1'b1;
      end else if (v == 0) begin
         m_nr = 1'b0;
      end
   endtask

   // Ticks until upd is seen (n = -1 if none within budget); optionally
   // changes score after tick chg_tick.
   task automatic wait_upd(input int budget, input int chg_tick,
                           input logic [10:0] chg_val, output int n);
      n = -1;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk_20Hz);
         @(negedge clk_20Hz);
         if (k == chg_tick) score = chg_val;
         if (upd === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int n_upd;
      int n_busy;
      rst   = 1'b1;
      score = 11'd0;
      #1;
      checks++;
      if ({cur_bcd, hi_bcd, upd, new_record, busy} !== 35'd0)
         begin errors++; $display("FAIL reset_outputs: got cur=%h hi=%h upd=%b nr=%b busy=%b, want all 0", cur_bcd, hi_bcd, upd, new_record, busy); end
      @(negedge clk_20Hz);
      rst = 1'b0;
      model_reset();
      n_upd  = 0;
      n_busy = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_20Hz);
         @(negedge clk_20Hz);
         if (upd === 1'b1) n_upd++;
         if (busy === 1'b1) n_busy++;
      end
      checks++;
      if (n_upd !== 0) begin errors++; $display("FAIL reset_idle_upd: got %0d pulses, want 0", n_upd); end
      checks++;
      if (n_busy !== 0) begin errors++; $display("FAIL reset_idle_busy: got %0d busy ticks, want 0", n_busy); end
   endtask

   task automatic test_first_score();
      score = 11'd1;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk_20Hz);
         @(negedge clk_20Hz);
         checks++;
         if (busy !== (k <= 12)) begin errors++; $display("FAIL first_busy tick %0d: got %b, want %b", k, busy, (k <= 12)); end
         checks++;
         if (upd !== (k == 13)) begin errors++; $display("FAIL first_upd tick %0d: got %b, want %b", k, upd, (k == 13)); end
      end
      model_convert(1);
      checks++;
      if (cur_bcd !== to_bcd(m_cur)) begin errors++; $display("FAIL first_cur: got %h, want %h", cur_bcd, to_bcd(m_cur)); end
      checks++;
      if (hi_bcd !== to_bcd(m_hi)) begin errors++; $display("FAIL first_hi: got %h, want %h", hi_bcd, to_bcd(m_hi)); end
      checks++;
      if (new_record !== m_nr) begin errors++; $display("FAIL first_nr: got %b, want %b", new_record, m_nr); end
      @(posedge clk_20Hz);
      @(negedge clk_20Hz);
      checks++;
      if (upd !== 1'b0) begin errors++; $display("FAIL first_upd_width: got %b, want 0", upd); end
   endtask

   task automatic test_max_score();
      int n;
      score = 11'd2047;
      wait_upd(20, 0, 11'd0, n);
      checks++;
      if (n !== 13) begin errors++; $display("FAIL max_latency: got %0d, want 13", n); end
      model_convert(2047);
      checks++;
      if (cur_bcd !== 16'h2047) begin errors++; $display("FAIL max_cur: got %h, want 2047", cur_bcd); end
      checks++;
      if (hi_bcd !== to_bcd(m_hi)) begin errors++; $display("FAIL max_hi: got %h, want %h", hi_bcd, to_bcd(m_hi)); end
      checks++;
      if (new_record !== m_nr) begin errors++; $display("FAIL max_nr: got %b, want %b", new_record, m_nr); end
   endtask

   task automatic test_mid_change();
      int n;
      score = 11'd5;
      wait_upd(20, 3, 11'd9, n);
      checks++;
      if (n !== 13) begin errors++; $display("FAIL mid_first_latency: got %0d, want 13", n); end
      model_convert(5);
      checks++;
      if (cur_bcd !== to_bcd(m_cur)) begin errors++; $display("FAIL mid_first_cur: got %h, want %h", cur_bcd, to_bcd(m_cur)); end
      wait_upd(20, 0, 11'd0, n);
      checks++;
      if (n !== 13) begin errors++; $display("FAIL mid_second_latency: got %0d, want 13", n); end
      model_convert(9);
      checks++;
      if (cur_bcd !== to_bcd(m_cur)) begin errors++; $display("FAIL mid_second_cur: got %h, want %h", cur_bcd, to_bcd(m_cur)); end
      checks++;
      if (hi_bcd !== to_bcd(m_hi) || new_record !== m_nr) begin errors++; $display("FAIL mid_hi_nr: got hi=%h nr=%b, want hi=%h nr=%b", hi_bcd, new_record, to_bcd(m_hi), m_nr); end
   endtask

   task automatic test_restart();
      int n;
      int seq [4] = '{123, 0, 123, 124};
      rst   = 1'b1;
      score = 11'd0;
      @(negedge clk_20Hz);
      rst = 1'b0;
      model_reset();
      foreach (seq[i]) begin
         score = 11'(seq[i]);
         wait_upd(20, 0, 11'd0, n);
         checks++;
         if (n !== 13) begin errors++; $display("FAIL restart_latency[%0d]: got %0d, want 13", i, n); end
         model_convert(seq[i]);
         checks++;
         if (cur_bcd !== to_bcd(m_cur)) begin errors++; $display("FAIL restart_cur[%0d]: got %h, want %h", i, cur_bcd, to_bcd(m_cur)); end
         checks++;
         if (hi_bcd !== to_bcd(m_hi)) begin errors++; $display("FAIL restart_hi[%0d]: got %h, want %h", i, hi_bcd, to_bcd(m_hi)); end
         checks++;
         if (new_record !== m_nr) begin errors++; $display("FAIL restart_nr[%0d]: got %b, want %b", i, new_record, m_nr); end
      end
   endtask

   task automatic test_async_reset();
      int n_upd;
      score = 11'd456;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk_20Hz);
         @(negedge clk_20Hz);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({cur_bcd, hi_bcd, upd, new_record, busy} !== 35'd0)
         begin errors++; $display("FAIL async_rst_outputs: got cur=%h hi=%h upd=%b nr=%b busy=%b, want all 0", cur_bcd, hi_bcd, upd, new_record, busy); end
      score = 11'd0;
      @(negedge clk_20Hz);
      rst = 1'b0;
      model_reset();
      n_upd = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_20Hz);
         @(negedge clk_20Hz);
         if (upd === 1'b1) n_upd++;
      end
      checks++;
      if (n_upd !== 0) begin errors++; $display("FAIL async_rst_no_upd: got %0d pulses, want 0", n_upd); end
   endtask

   task automatic test_random();
      int n;
      int v1;
      int v2;
      int chg;
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0:       v1 = 0;
            1:       v1 = m_hi;
            default: v1 = int'($urandom_range(0, 2047));
         endcase
         chg = 0;
         v2  = v1;
         if (v1 != m_last && $urandom_range(0, 1) == 1) begin
            chg = int'($urandom_range(2, 11));
            v2  = int'($urandom_range(0, 2047));
         end
         score = 11'(v1);
         if (v1 == m_last) begin
            wait_upd(15, 0, 11'd0, n);
            checks++;
            if (n !== -1) begin errors++; $display("FAIL rand_same[%0d]: upd at tick %0d, want none", i, n); end
         end else begin
            wait_upd(20, chg, 11'(v2), n);
            checks++;
            if (n !== 13) begin errors++; $display("FAIL rand_latency[%0d]: got %0d, want 13", i, n); end
            model_convert(v1);
            checks++;
            if (cur_bcd !== to_bcd(m_cur) || hi_bcd !== to_bcd(m_hi) || new_record !== m_nr)
               begin errors++; $display("FAIL rand_result[%0d] v=%0d: got cur=%h hi=%h nr=%b, want cur=%h hi=%h nr=%b", i, v1, cur_bcd, hi_bcd, new_record, to_bcd(m_cur), to_bcd(m_hi), m_nr); end
            if (v2 != m_last) begin
               wait_upd(20, 0, 11'd0, n);
               checks++;
               if (n !== 13) begin errors++; $display("FAIL rand_follow_latency[%0d]: got %0d, want 13", i, n); end
               model_convert(v2);
               checks++;
               if (cur_bcd !== to_bcd(m_cur) || hi_bcd !== to_bcd(m_hi) || new_record !== m_nr)
                  begin errors++; $display("FAIL rand_follow_result[%0d] v=%0d: got cur=%h hi=%h nr=%b, want cur=%h hi=%h nr=%b", i, v2, cur_bcd, hi_bcd, new_record, to_bcd(m_cur), to_bcd(m_hi), m_nr); end
            end
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      score  = 11'd0;
      model_reset();
      test_reset();
      test_first_score();
      test_max_score();
      test_mid_change();
      test_restart();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
